ex_cond_stage: RTL and testbench
================================

# ex_cond_stage

Execute-side condition and flags stage that sits directly downstream of the 16-bit ALU. It consumes the ALU result and its raw Z/N/V/C outputs, holds the architectural NZCV status register, and evaluates the instruction's 4-bit condition code against the current flags. It registers the qualified result into the EX/MEM pipeline slot under a valid/ready handshake with flush support.

## Interface
Parameters:
- `DATA_W`, 16, result width (must match ALU output width)
- `RD_W`, 3, destination register index width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream (ALU) holds a valid instruction
- `in_ready`  out  1  stage can accept this cycle
- `alu_result`  in  DATA_W  ALU output
- `alu_z`, `alu_n`, `alu_v`, `alu_c`  in  1 each  raw ALU flags for this instruction
- `cond`  in  4  ARM condition field
- `set_flags`  in  1  S bit: update NZCV if the instruction executes
- `wr_en`  in  1  instruction writes `rd`
- `rd`  in  RD_W  destination register
- `flush`  in  1  squash the held entry and block acceptance this cycle
- `out_valid`  out  1  EX/MEM slot holds an entry
- `out_ready`  in  1  downstream accepts the entry
- `out_result`  out  DATA_W  registered result
- `out_rd`  out  RD_W  registered destination
- `out_wr_en`  out  1  `wr_en` AND condition passed
- `out_cond_pass`  out  1  condition outcome of the held entry
- `flags`  out  4  architectural {N,Z,C,V}

## Operation
- Accept = `in_valid & in_ready & ~flush`; `in_ready = ~out_valid | out_ready`.
- Condition is evaluated combinationally against the current `flags` register, i.e. the flags before this instruction:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL always; F NV never.
- On accept:
  - load `out_result`, `out_rd`, `out_cond_pass`.
  - `out_wr_en = wr_en & pass`.
  - set `out_valid` = 1.
- On accept with pass & `set_flags`: `flags` <= {alu_n, alu_z, alu_c, alu_v` in next-state order N,Z,C,V}. Otherwise `flags` is held.
- A failed-condition instruction still occupies the slot (`out_valid`=1, `out_wr_en`=0, `out_cond_pass`=0) and does not update flags.
- When `out_valid & out_ready` and there is no accept, `out_valid` goes to 0.
- Pop and accept in the same cycle: the slot is replaced with no bubble.
- Flush: `out_valid` goes to 0 next edge, no accept, and no flag update that cycle. `flags` keeps its value from earlier accepted instructions.
- Outputs are stable while `out_valid & ~out_ready`.

## Timing
- Reset (async, `rst_n`=0):
  - `out_valid`=0, `flags`=4'b0000, `out_result`=0, `out_rd`=0, `out_wr_en`=0, `out_cond_pass`=0.
  - `in_ready`=1 after reset.
- Latency: 1 cycle from accept to `out_valid`.
- Flag update is visible on `flags` the cycle after accept. A back-to-back dependent instruction accepted on the next cycle evaluates against the updated flags, so there is no bubble.
- Throughput: 1 per cycle while `out_ready`=1.
- Reset asserted mid-stall: the entry is dropped and flags are cleared immediately, without waiting for a clock edge.
- `in_ready` is combinational from `out_valid` and `out_ready` only. It has no path from `in_valid`.

## Configuration
- `EX_COND_EXEC_EN` defined: full condition evaluation as above.
- `EX_COND_EXEC_EN` undefined:
  - `cond` is ignored and every instruction passes, so `out_cond_pass`=1 and `out_wr_en`=`wr_en`.
  - `set_flags` still controls flag updates.
  - The `cond` port remains in the interface.

## Test plan
- Reset: after `rst_n` deasserts → `flags`=0000, `out_valid`=0, `in_ready`=1.
- SUBS then BEQ-type:
  - Cycle 0: accept result 0x0000, z=1, `set_flags`=1, cond=E → `flags`=0100.
  - Cycle 1: accept cond=0, `wr_en`=1, result 0x1234 → `out_wr_en`=1, `out_cond_pass`=1.
- Failed condition: with `flags`=0000, accept cond=0 (EQ), `wr_en`=1, `set_flags`=1, n=1 → `out_valid`=1, `out_wr_en`=0, `flags` stays 0000.
- Signed conditions:
  - `flags`=1001 (N=1, V=1): GT with Z=0 passes and LT fails.
  - `flags`=1000: GE fails.
  - cond=F always fails.
- Backpressure:
  - Hold `out_ready`=0 with the slot full → `in_ready`=0, `out_result` stable for 5 cycles, `flags` unchanged despite `in_valid`=1.
  - Release → pop and new accept in the same cycle.
- Flush: assert `flush` with the slot full and `in_valid`=1 → next cycle `out_valid`=0, new entry not taken, `flags` unchanged.
- Config: with `EX_COND_EXEC_EN` undefined, repeat the failed-condition case → `out_wr_en`=1 and `flags`=1000.

Source files
------------

// File: rtl/ex_cond_stage.sv
// EX condition/flags stage: NZCV register, cond-code evaluation, EX/MEM slot.
// Define EX_COND_EXEC_EN for full conditional execution; otherwise all pass.
module ex_cond_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              alu_c,
  input  logic [3:0]        cond,
  input  logic              set_flags,
  input  logic              wr_en,
  input  logic [RD_W-1:0]   rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              out_cond_pass,
  output logic [3:0]        flags
);

  logic accept;
  logic pass;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

`ifdef EX_COND_EXEC_EN
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = flags;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      4'h0: pass = f_z;
      4'h1: pass = ~f_z;
      4'h2: pass = f_c;
      4'h3: pass = ~f_c;
      4'h4: pass = f_n;
      4'h5: pass = ~f_n;
      4'h6: pass = f_v;
      4'h7: pass = ~f_v;
      4'h8: pass = f_c & ~f_z;
      4'h9: pass = ~f_c | f_z;
      4'ha: pass = (f_n == f_v);
      4'hb: pass = (f_n != f_v);
      4'hc: pass = ~f_z & (f_n == f_v);
      4'hd: pass = f_z | (f_n != f_v);
      4'he: pass = 1'b1;
      4'hf: pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign pass        = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_wr_en     <= 1'b0;
      out_cond_pass <= 1'b0;
      flags         <= 4'b0000;
    end else begin
      if (accept) begin
        out_valid     <= 1'b1;
        out_result    <= alu_result;
        out_rd        <= rd;
        out_wr_en     <= wr_en & pass;
        out_cond_pass <= pass;
        if (pass & set_flags)
          flags <= {alu_n, alu_z, alu_c, alu_v};
      end else if (flush | out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_cond_stage.sv
// Scoreboard bench for ex_cond_stage: reference flag/cond model,
// expected entries queued on accept and checked while held / on pop.
module tb_ex_cond_stage;

  localparam int DATA_W = 16;
  localparam int RD_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_n, alu_v, alu_c;
  logic [3:0]        cond;
  logic              set_flags;
  logic              wr_en;
  logic [RD_W-1:0]   rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wr_en;
  logic              out_cond_pass;
  logic [3:0]        flags;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [RD_W-1:0]   rd;
    logic              we;
    logic              pass;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_flags;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  ex_cond_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
    .cond(cond), .set_flags(set_flags), .wr_en(wr_en), .rd(rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_cond_pass(out_cond_pass),
    .flags(flags)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_pass(input logic [3:0] cd,
                                    input logic [3:0] f);
`ifdef EX_COND_EXEC_EN
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (cd == cd) && (f == f);
`endif
  endfunction

  // Drive one cycle of inputs, model the handshake at negedge, check after edge.
  task automatic cyc(input logic iv, input logic [DATA_W-1:0] res,
                     input logic [3:0] nzcv, input logic [3:0] cd,
                     input logic sf, input logic we,
                     input logic [RD_W-1:0] r, input logic fl,
                     input logic ordy);
    logic ir, acc, p;
    exp_t e;
    in_valid = iv; alu_result = res;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
    cond = cd; set_flags = sf; wr_en = we; rd = r;
    flush = fl; out_ready = ordy;
    #4;
    ir = (q.size() == 0) || ordy;
    chk("in_ready", in_ready, ir);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wr_en", out_wr_en, q[0].we);
      chk("out_cond_pass", out_cond_pass, q[0].pass);
      if (fl || ordy) void'(q.pop_front());
    end
    acc = iv && ir && !fl;
    if (acc) begin
      p = ref_pass(cd, m_flags);
      e.res = res; e.rd = r; e.we = we && p; e.pass = p;
      q.push_back(e);
      if (p && sf) m_flags = nzcv;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("flags", flags, m_flags);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, 4'h0, 4'he, 1'b0, 1'b0, '0, 1'b0, ordy);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; alu_result = '0;
    {alu_n, alu_z, alu_c, alu_v} = 4'h0;
    cond = 4'h0; set_flags = 0; wr_en = 0; rd = '0;
    flush = 0; out_ready = 1'b1;
    m_flags = 4'h0;
    #12;
    chk("rst_flags", flags, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 16'h0);
    chk("rst_out_wr_en", out_wr_en, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SUBS setting Z then dependent EQ
    cyc(1, 16'h0000, 4'b0100, 4'he, 1, 1, 3'd1, 0, 1);
    cyc(1, 16'h1234, 4'b0000, 4'h0, 0, 1, 3'd2, 0, 1);
    // clear flags, then EQ with n=1 set_flags
    cyc(1, 16'h0005, 4'b0000, 4'he, 1, 1, 3'd3, 0, 1);
    cyc(1, 16'h0077, 4'b1000, 4'h0, 1, 1, 3'd4, 0, 1);
    // signed conditions with N=1,V=1
    cyc(1, 16'h0001, 4'b1001, 4'he, 1, 0, 3'd0, 0, 1);
    cyc(1, 16'h0102, 4'b0000, 4'hc, 0, 1, 3'd5, 0, 1);
    cyc(1, 16'h0103, 4'b0000, 4'hb, 0, 1, 3'd6, 0, 1);
    cyc(1, 16'h0002, 4'b1000, 4'he, 1, 0, 3'd0, 0, 1);
    cyc(1, 16'h0104, 4'b0011, 4'ha, 1, 1, 3'd7, 0, 1);
    cyc(1, 16'h0105, 4'b0111, 4'hf, 1, 1, 3'd1, 0, 1);
    idle(1);

    // backpressure: fill, stall 5 cycles with in_valid high, release
    cyc(1, 16'hbeef, 4'b0010, 4'he, 1, 1, 3'd2, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, 16'h4000 + 16'(i), 4'b0101, 4'he, 1, 1, 3'd3, 0, 0);
    cyc(1, 16'hcafe, 4'b1100, 4'he, 1, 1, 3'd4, 0, 1);
    idle(1);

    // flush with slot full and new instruction offered
    cyc(1, 16'h5555, 4'b0001, 4'he, 1, 1, 3'd5, 0, 0);
    cyc(1, 16'h6666, 4'b1110, 4'he, 1, 1, 3'd6, 1, 0);
    idle(1);

    // random traffic
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
          4'($urandom), 4'($urandom), 1'($urandom),
          1'($urandom), 3'($urandom),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 3) != 0));
    idle(1);

    // async reset while stalled
    cyc(1, 16'h0abc, 4'b1010, 4'he, 1, 1, 3'd7, 0, 0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_flags = 4'h0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_flags", flags, 4'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    cyc(1, 16'h0f0f, 4'b0110, 4'he, 1, 1, 3'd1, 0, 1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
